// File: rtl/clock_divider_bank_pkg.sv
// Shared constants and helpers for the programmable clock divider bank.
// Holds the default frequency plan and the width and mode types used by the channel slices.
package clock_divider_bank_pkg;

    localparam int CNT_W_DEF        = 32;
    localparam int SYS_FREQ_DEF     = 50_000_000;
    localparam int DEFAULT_FREQ_DEF = 1000;

    // Per-channel action for one clkin edge; reset sits above all of these.
    typedef enum logic [1:0] {
        MODE_HOLD,
        MODE_RUN,
        MODE_SYNC
    } ch_mode_e;

    function automatic int calc_half(input int sys_freq, input int freq);
        return sys_freq / 2 / freq;
    endfunction

    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clock_divider_bank_if.sv
// Configuration write bus for the divider bank.
// It carries a write strobe, the target channel and the new half-period.
interface clock_divider_bank_if
    import clock_divider_bank_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CNT_W_DEF
) ();

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_half;

    modport master (output cfg_we, output cfg_ch, output cfg_half);
    modport slave  (input  cfg_we, input  cfg_ch, input  cfg_half);

endinterface

// File: rtl/clock_divider_bank_channel.sv
// One divider slice: half-period counter, toggle flop, tick pulse and a deferred reload
// that only takes effect on a toggle edge so no half-period is ever cut short.
module clock_divider_channel
    import clock_divider_bank_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DEFAULT_HALF = calc_half(SYS_FREQ_DEF, DEFAULT_FREQ_DEF)
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             we,
    input  logic [CNT_W-1:0] wr_half,
    output logic             clkout,
    output logic             tick,
    output logic             reload_pend
);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] active_half, active_nxt;
    logic [CNT_W-1:0] pending_half, pending_nxt;
    logic             clk_nxt, tick_nxt, pend_nxt;
    logic [CNT_W:0]   cnt_inc, eff_half;
    logic             hit;
    ch_mode_e         mode;

    always_comb begin
        mode        = sync ? MODE_SYNC : (en ? MODE_RUN : MODE_HOLD);
        // One extra bit so a counter at all-ones compares correctly instead of wrapping.
        cnt_inc     = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
        eff_half    = (active_half == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, active_half};
        hit         = (cnt_inc >= eff_half);

        cnt_nxt     = cnt;
        clk_nxt     = clkout;
        tick_nxt    = 1'b0;
        active_nxt  = active_half;
        pending_nxt = pending_half;
        pend_nxt    = reload_pend;

        case (mode)
            MODE_SYNC: begin
                cnt_nxt = '0;
                clk_nxt = 1'b0;
                if (we) begin
                    active_nxt  = wr_half;
                    pending_nxt = wr_half;
                end else if (reload_pend) begin
                    active_nxt  = pending_half;
                end
                pend_nxt = 1'b0;
            end
            MODE_RUN: begin
                if (hit) begin
                    cnt_nxt  = '0;
                    clk_nxt  = ~clkout;
                    tick_nxt = ~clkout;
                    if (we) begin
                        active_nxt  = wr_half;
                        pending_nxt = wr_half;
                    end else if (reload_pend) begin
                        active_nxt  = pending_half;
                    end
                    pend_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt_inc[CNT_W-1:0];
                    if (we) begin
                        pending_nxt = wr_half;
                        pend_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                // Stopped channels have no half-period in flight, so writes land at once.
                if (we) begin
                    active_nxt  = wr_half;
                    pending_nxt = wr_half;
                    pend_nxt    = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            cnt          <= '0;
            clkout       <= 1'b0;
            tick         <= 1'b0;
            active_half  <= CNT_W'(DEFAULT_HALF);
            pending_half <= CNT_W'(DEFAULT_HALF);
            reload_pend  <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            clkout       <= clk_nxt;
            tick         <= tick_nxt;
            active_half  <= active_nxt;
            pending_half <= pending_nxt;
            reload_pend  <= pend_nxt;
        end
    end

endmodule

// File: rtl/clock_divider_bank.sv
// NUM_CH programmable square-wave clock generators derived from clkin.
// The top only decodes the configuration channel and fans the sync pulse out.
module clock_divider_bank
    import clock_divider_bank_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int SYS_FREQ     = SYS_FREQ_DEF,
    parameter int DEFAULT_FREQ = DEFAULT_FREQ_DEF,
    parameter int DEFAULT_HALF = calc_half(SYS_FREQ, DEFAULT_FREQ)
) (
    input  logic                 clkin,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    ch_en,
    clock_divider_bank_if.slave  cfg,
    input  logic                 sync,
    output logic [NUM_CH-1:0]    clkout,
    output logic [NUM_CH-1:0]    tick,
    output logic [NUM_CH-1:0]    reload_pend
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic we_ch;

        // Out-of-range channel numbers match no slice and are dropped.
        assign we_ch = cfg.cfg_we && (int'(cfg.cfg_ch) == i);

        clock_divider_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clkin       (clkin),
            .rst_n       (rst_n),
            .en          (ch_en[i]),
            .sync        (sync),
            .we          (we_ch),
            .wr_half     (cfg.cfg_half),
            .clkout      (clkout[i]),
            .tick        (tick[i]),
            .reload_pend (reload_pend[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank: stimulus queues time-stamped expectations,
// a monitor compares them against the outputs on the falling edge.
module tb_clock_divider_bank;

    localparam int N = 5;
    localparam int H = 25000;

    typedef struct {
        int          at;
        logic [N-1:0] mask;
        logic [N-1:0] clk;
        logic [N-1:0] tk;
        logic [N-1:0] pd;
        string        name;
    } exp_t;

    logic         clkin;
    logic         rst_n;
    logic [N-1:0] ch_en;
    logic         sync;
    logic [N-1:0] clkout;
    logic [N-1:0] tick;
    logic [N-1:0] reload_pend;

    int   cyc    = 0;
    int   passed = 0;
    int   total  = 0;
    exp_t sbq[$];

    clock_divider_bank_if #(.NUM_CH(N), .CNT_W(32)) cfg_bus ();

    clock_divider_bank #(.NUM_CH(N), .CNT_W(32)) dut (
        .clkin       (clkin),
        .rst_n       (rst_n),
        .ch_en       (ch_en),
        .cfg         (cfg_bus),
        .sync        (sync),
        .clkout      (clkout),
        .tick        (tick),
        .reload_pend (reload_pend)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    initial forever begin
        @(posedge clkin);
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d, required finish before it", cyc);
        $fatal(1);
    end

    function automatic void expect_ch(input int at, input string nm, input int ch,
                                      input bit c, input bit t, input bit p);
        exp_t e;
        e.at = at; e.name = nm;
        e.mask = '0; e.clk = '0; e.tk = '0; e.pd = '0;
        e.mask[ch] = 1'b1; e.clk[ch] = c; e.tk[ch] = t; e.pd[ch] = p;
        sbq.push_back(e);
    endfunction

    function automatic void expect_all(input int at, input string nm, input logic [N-1:0] c,
                                       input logic [N-1:0] t, input logic [N-1:0] p);
        exp_t e;
        e.at = at; e.name = nm; e.mask = '1; e.clk = c; e.tk = t; e.pd = p;
        sbq.push_back(e);
    endfunction

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clkin);
    endtask

    task automatic write_cfg(input int ch, input int half);
        cfg_bus.cfg_we   = 1'b1;
        cfg_bus.cfg_ch   = 3'(ch);
        cfg_bus.cfg_half = 32'(half);
    endtask

    // Monitor: retire every expectation due at this cycle.
    initial forever begin
        @(negedge clkin);
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].at <= cyc) begin
                total++;
                if (sbq[i].at < cyc)
                    $display("FAIL %s: check due at cycle %0d was skipped (now %0d)",
                             sbq[i].name, sbq[i].at, cyc);
                else if (((clkout ^ sbq[i].clk) & sbq[i].mask) != '0 ||
                         ((tick ^ sbq[i].tk) & sbq[i].mask) != '0 ||
                         ((reload_pend ^ sbq[i].pd) & sbq[i].mask) != '0)
                    $display("FAIL %s @%0d: clkout=%b tick=%b pend=%b, required clkout=%b tick=%b pend=%b (mask %b)",
                             sbq[i].name, cyc, clkout, tick, reload_pend,
                             sbq[i].clk, sbq[i].tk, sbq[i].pd, sbq[i].mask);
                else
                    passed++;
                sbq.delete(i);
            end
        end
    end

    initial begin
        int b, c, d, e, f, g;
        rst_n = 1'b0; ch_en = '0; sync = 1'b0;
        cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_ch = '0; cfg_bus.cfg_half = '0;

        // 1: defaults, all channels in phase
        wait_to(3);
        expect_all(4, "reset", '0, '0, '0);
        wait_to(4);
        rst_n = 1'b1; ch_en = '1; b = cyc;
        expect_all(b + H - 1,     "t1_before_rise", '0, '0, '0);
        expect_all(b + H,         "t1_rise",        '1, '1, '0);
        expect_all(b + H + 1,     "t1_tick_1cyc",   '1, '0, '0);
        expect_all(b + 2 * H - 1, "t1_before_fall", '1, '0, '0);
        expect_all(b + 2 * H,     "t1_fall",        '0, '0, '0);

        // 2: write ch1 while disabled, then run at half=3
        wait_to(b + 2 * H);
        c = cyc; ch_en = '0;
        wait_to(c + 1);
        write_cfg(1, 3);
        expect_ch(c + 2, "t2_wr_disabled", 1, 0, 0, 0);
        wait_to(c + 2);
        cfg_bus.cfg_we = 1'b0; ch_en = 5'b00010;
        expect_ch(c + 4,  "t2_pre_rise",  1, 0, 0, 0);
        expect_ch(c + 5,  "t2_rise1",     1, 1, 1, 0);
        expect_ch(c + 6,  "t2_after",     1, 1, 0, 0);
        expect_ch(c + 8,  "t2_fall",      1, 0, 0, 0);
        expect_ch(c + 11, "t2_rise2",     1, 1, 1, 0);
        expect_ch(c + 12, "t2_after2",    1, 1, 0, 0);

        // 3: glitch-free reload on ch2 from 10 to 2
        wait_to(c + 12);
        d = cyc; write_cfg(2, 10);
        wait_to(d + 1);
        cfg_bus.cfg_we = 1'b0; ch_en = 5'b00110;
        wait_to(d + 5);
        write_cfg(2, 2);
        expect_ch(d + 6,  "t3_pend_set",   2, 0, 0, 1);
        expect_ch(d + 10, "t3_full_half",  2, 0, 0, 1);
        expect_ch(d + 11, "t3_rise",       2, 1, 1, 0);
        expect_ch(d + 12, "t3_high",       2, 1, 0, 0);
        expect_ch(d + 13, "t3_new_fall",   2, 0, 0, 0);
        expect_ch(d + 15, "t3_new_rise",   2, 1, 1, 0);
        wait_to(d + 6);
        cfg_bus.cfg_we = 1'b0;

        // 4: half=0 then half=1 (write coincident with a toggle)
        wait_to(d + 15);
        e = cyc; write_cfg(3, 0);
        wait_to(e + 1);
        cfg_bus.cfg_we = 1'b0; ch_en = 5'b01110;
        expect_ch(e + 2, "t4_h0_rise1", 3, 1, 1, 0);
        expect_ch(e + 3, "t4_h0_fall1", 3, 0, 0, 0);
        expect_ch(e + 4, "t4_h0_rise2", 3, 1, 1, 0);
        expect_ch(e + 5, "t4_h0_fall2", 3, 0, 0, 0);
        wait_to(e + 5);
        write_cfg(3, 1);
        expect_ch(e + 6, "t4_h1_rise1", 3, 1, 1, 0);
        expect_ch(e + 7, "t4_h1_fall",  3, 0, 0, 0);
        expect_ch(e + 8, "t4_h1_rise2", 3, 1, 1, 0);
        wait_to(e + 6);
        cfg_bus.cfg_we = 1'b0;

        // 5: sync realignment (with a coincident write) and enable freeze
        wait_to(e + 8);
        f = cyc; write_cfg(0, 5);
        wait_to(f + 1);
        write_cfg(4, 7);
        wait_to(f + 2);
        cfg_bus.cfg_we = 1'b0; ch_en = '1;
        expect_ch(f + 7, "t5_ch0_rise", 0, 1, 1, 0);
        expect_ch(f + 9, "t5_ch4_rise", 4, 1, 1, 0);
        wait_to(f + 10);
        sync = 1'b1; write_cfg(2, 4);
        expect_all(f + 11, "t5_sync_clear", '0, '0, '0);
        wait_to(f + 11);
        sync = 1'b0; cfg_bus.cfg_we = 1'b0;
        expect_ch(f + 12, "t5_ch3_align",  3, 1, 1, 0);
        expect_ch(f + 13, "t5_ch2_nohalf2", 2, 0, 0, 0);
        expect_ch(f + 14, "t5_ch1_align",  1, 1, 1, 0);
        expect_ch(f + 15, "t5_ch2_half4",  2, 1, 1, 0);
        expect_ch(f + 15, "t5_ch0_pre",    0, 0, 0, 0);
        expect_ch(f + 16, "t5_ch0_align",  0, 1, 1, 0);
        expect_ch(f + 17, "t5_ch4_pre",    4, 0, 0, 0);
        expect_ch(f + 18, "t5_ch4_align",  4, 1, 1, 0);
        wait_to(f + 18);
        ch_en = 5'b11110;
        expect_ch(f + 19, "t5_frozen_a", 0, 1, 0, 0);
        expect_ch(f + 21, "t5_frozen_b", 0, 1, 0, 0);
        expect_ch(f + 23, "t5_frozen_c", 0, 1, 0, 0);
        wait_to(f + 23);
        ch_en = '1;
        expect_ch(f + 25, "t5_resume_hold", 0, 1, 0, 0);
        expect_ch(f + 26, "t5_resume_fall", 0, 0, 0, 0);

        // 6: sync applies a pending reload; reset drops one; out-of-range write
        wait_to(f + 26);
        g = cyc; write_cfg(1, 6);
        expect_ch(g + 1, "t6_ch1_pend", 1, 1, 0, 1);
        wait_to(g + 1);
        cfg_bus.cfg_we = 1'b0; sync = 1'b1;
        expect_ch(g + 2, "t6_sync_apply", 1, 0, 0, 0);
        wait_to(g + 2);
        sync = 1'b0;
        expect_ch(g + 5, "t6_not_old3",  1, 0, 0, 0);
        expect_ch(g + 7, "t6_pre_rise6", 1, 0, 0, 0);
        expect_ch(g + 8, "t6_rise6",     1, 1, 1, 0);
        wait_to(g + 9);
        write_cfg(4, 3);
        expect_ch(g + 10, "t6_ch4_pend", 4, 1, 0, 1);
        wait_to(g + 10);
        cfg_bus.cfg_we = 1'b0; rst_n = 1'b0;
        expect_all(g + 11, "t6_reset", '0, '0, '0);
        wait_to(g + 11);
        rst_n = 1'b1; write_cfg(N, 2);
        expect_all(g + 12, "t6_bad_ch_ignored", '0, '0, '0);
        wait_to(g + 12);
        cfg_bus.cfg_we = 1'b0;
        expect_all(g + 21, "t6_default_restored", '0, '0, '0);

        wait_to(g + 22);
        for (int k = 0; k < 30 && sbq.size() != 0; k++) @(negedge clkin);
        if (sbq.size() != 0) begin
            $display("FAIL drain: %0d checks still queued, required 0", sbq.size());
            total += sbq.size();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
